// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: FSM encodings, width defaults, counter helper.
// Imported by fetch_unit and fetch_unit_fifo.
package fetch_unit_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic [15:0] satAdd(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch queue: DEPTH x W entries, power-of-two pointers, flush clears.
// Ports: push/wdata in, pop/rdata head out, flush, full, empty, count.
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int W     = ADDR_W_DEF + DATA_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] cnt;
  logic          doPush;
  logic          doPop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;
  assign rdata = mem[rdPtr];

  // A full queue may still take a push when the head leaves this cycle.
  assign doPop  = pop & ~empty & ~flush;
  assign doPush = push & ~flush & (~full | doPop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= (wrPtr + AW'(1)) & PTR_MASK;
      end
      if (doPop) begin
        rdPtr <= (rdPtr + AW'(1)) & PTR_MASK;
      end
      cnt <= cnt + CW'(doPush) - CW'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, one outstanding imem request, prefetch queue,
// valid/ready hand-off to decode, redirect flush.
// Ports: clk, rst (async high); imem_req/imem_addr out, imem_valid/
// imem_rdata in; redirect/redirect_addr in; instr_valid/instr_data/
// instr_pc out, instr_ready in.
// FETCH_PERF_EN adds perf_fetched and perf_flushed (16-bit, saturating).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_flushed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + DATA_W;

  logic [1:0]        state;
  logic [1:0]        stateNext;
  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] pcNext;
  logic              reqQ;
  logic              reqNext;

  logic              fifoPush;
  logic              fifoPop;
  logic              fifoFlush;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CW-1:0]     fifoCount;
  logic [CW-1:0]     countAfter;
  logic              spaceAfter;
  logic [EW-1:0]     headEntry;

  // fetchPc is the address of the outstanding request, so it also
  // serves as imem_addr and as the PC tag of the returning word.
  assign imem_req    = reqQ;
  assign imem_addr   = fetchPc;
  assign instr_valid = ~fifoEmpty;
  assign instr_data  = headEntry[DATA_W-1:0];
  assign instr_pc    = headEntry[EW-1:DATA_W];

  assign fifoFlush  = redirect;
  assign fifoPop    = instr_valid & instr_ready & ~redirect;
  assign fifoPush   = (state == ST_WAIT) & imem_valid & ~redirect;
  assign countAfter = fifoCount + CW'(fifoPush) - CW'(fifoPop);
  assign spaceAfter = countAfter < CW'(DEPTH);

  fetch_unit_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifoPush),
    .pop   (fifoPop),
    .flush (fifoFlush),
    .wdata ({fetchPc, imem_rdata}),
    .rdata (headEntry),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  always_comb begin
    stateNext = state;
    pcNext    = fetchPc;
    reqNext   = 1'b0;
    case (state)
      ST_FETCH: begin
        if (redirect) begin
          pcNext = redirect_addr;
        end else if (~fifoFull) begin
          reqNext   = 1'b1;
          stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pcNext    = redirect_addr;
          // A response landing with the redirect is simply dropped.
          stateNext = imem_valid ? ST_FETCH : ST_DRAIN;
        end else if (imem_valid) begin
          pcNext = fetchPc + ADDR_W'(1);
          if (spaceAfter) begin
            reqNext = 1'b1;
          end else begin
            stateNext = ST_FETCH;
          end
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          pcNext = redirect_addr;
        end
        if (imem_valid) begin
          stateNext = ST_FETCH;
        end
      end
      default: begin
        stateNext = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_FETCH;
      fetchPc <= RESET_PC;
      reqQ    <= 1'b0;
    end else begin
      state   <= stateNext;
      fetchPc <= pcNext;
      reqQ    <= reqNext;
    end
  end

`ifdef FETCH_PERF_EN
  logic        discard;
  logic [15:0] flushInc;

  // Responses thrown away: draining, or arriving with a redirect.
  assign discard  = imem_valid &
                    ((state == ST_DRAIN) |
                     ((state == ST_WAIT) & redirect));
  assign flushInc = (redirect ? 16'(fifoCount) : 16'd0) +
                    16'(discard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= satAdd(perf_fetched, 16'(fifoPush));
      perf_flushed <= satAdd(perf_flushed, flushInc);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed tables, corner sequences, random run
// against a stream-level model of requests and delivered instructions.
module tb_fetch_unit;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_valid;
  logic [DW-1:0] imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          instr_valid;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
`ifdef FETCH_PERF_EN
  logic [15:0]   perf_fetched;
  logic [15:0]   perf_flushed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_flushed  (perf_flushed)
`endif
  );

  typedef struct {
    logic        ready;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expIv;
    logic [31:0] expPc;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic        ready;
  logic        redir;
  logic [31:0] redirAddr;
  int          lat;
  bit          randLat;
  bit          memBusy;
  int          memCnt;
  logic [31:0] memAddr;
  logic [31:0] expReq;
  logic [31:0] expDel;
  int          reqCnt;
  int          delCnt;
  logic [31:0] reqLog[$];
  logic [31:0] delLog[$];

  vec_t        t1[8];
  logic [31:0] t5Exp[3];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: memory model, input drive, stream scoreboard.
  task automatic step();
    @(negedge clk);
    imem_valid = 1'b0;
    if (memBusy) begin
      memCnt--;
      if (memCnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = memWord(memAddr);
        memBusy    = 1'b0;
      end
    end
    if (imem_req) begin
      chk("one_outstanding", {31'b0, memBusy | imem_valid}, 32'd0);
      chk("req_addr", imem_addr, expReq);
      expReq = imem_addr + 32'd1;
      reqCnt++;
      reqLog.push_back(imem_addr);
      memBusy = 1'b1;
      memCnt  = randLat ? int'($urandom_range(1, 3)) : lat;
      memAddr = imem_addr;
    end
    instr_ready   = ready;
    redirect      = redir;
    redirect_addr = redirAddr;
    if (instr_valid && instr_ready && !redirect) begin
      chk("deliver_pc", instr_pc, expDel);
      chk("deliver_data", instr_data, memWord(instr_pc));
      expDel = instr_pc + 32'd1;
      delCnt++;
      delLog.push_back(instr_pc);
    end
    if (redirect) begin
      expReq = redirAddr;
      expDel = redirAddr;
    end
  endtask

  task automatic resetDut();
    rst           = 1'b1;
    ready         = 1'b0;
    redir         = 1'b0;
    redirAddr     = '0;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    imem_valid    = 1'b0;
    imem_rdata    = '0;
    memBusy       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_iv", {31'b0, instr_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", {16'b0, perf_fetched}, 32'd0);
    chk("rst_perf_flushed", {16'b0, perf_flushed}, 32'd0);
`endif
    expReq = '0;
    expDel = '0;
    reqCnt = 0;
    delCnt = 0;
    reqLog.delete();
    delLog.delete();
    rst = 1'b0;
  endtask

  initial begin
    // ready, req, addr, iv, pc for cycles 1..8 after reset release
    t1[0] = '{1'b1, 1'b1, 32'd0, 1'b0, 32'd0};
    t1[1] = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    t1[2] = '{1'b1, 1'b1, 32'd1, 1'b1, 32'd0};
    t1[3] = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    t1[4] = '{1'b1, 1'b1, 32'd2, 1'b1, 32'd1};
    t1[5] = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    t1[6] = '{1'b1, 1'b1, 32'd3, 1'b1, 32'd2};
    t1[7] = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd0};
    t5Exp[0] = 32'hFFFF_FFFF;
    t5Exp[1] = 32'h0000_0000;
    t5Exp[2] = 32'h0000_0001;
    randLat = 1'b0;
    lat     = 1;

    // T1: cycle-exact start-up with 1-cycle memory
    resetDut();
    for (int i = 0; i < 8; i++) begin
      ready = t1[i].ready;
      step();
      chk($sformatf("t1_req_c%0d", i + 1), {31'b0, imem_req},
          {31'b0, t1[i].expReq});
      if (t1[i].expReq)
        chk($sformatf("t1_addr_c%0d", i + 1), imem_addr, t1[i].expAddr);
      chk($sformatf("t1_iv_c%0d", i + 1), {31'b0, instr_valid},
          {31'b0, t1[i].expIv});
      if (t1[i].expIv)
        chk($sformatf("t1_pc_c%0d", i + 1), instr_pc, t1[i].expPc);
    end

    // T2: decode stalled, queue fills to DEPTH, then drains in order
    resetDut();
    ready = 1'b0;
    repeat (12) step();
    chk("t2_reqs_when_full", reqCnt, DEPTH);
    chk("t2_iv_full", {31'b0, instr_valid}, 32'd1);
    chk("t2_head_pc", instr_pc, 32'd0);
    ready = 1'b1;
    for (int i = 0; i < 40 && (delCnt < 4 || reqCnt < 5); i++) step();
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_drain_pc%0d", i), at(delLog, i), i);
    chk("t2_resume_addr", at(reqLog, 4), 32'd4);

    // T3: redirect while a 3-cycle request is outstanding
    resetDut();
    lat   = 3;
    ready = 1'b1;
    step();
    redir     = 1'b1;
    redirAddr = 32'h40;
    step();
    redir = 1'b0;
    for (int i = 0; i < 40 && delCnt < 1; i++) step();
    chk("t3_next_req", at(reqLog, 1), 32'h40);
    chk("t3_first_pc", at(delLog, 0), 32'h40);

    // T4: redirect together with a response and a pop
    resetDut();
    lat   = 1;
    ready = 1'b0;
    repeat (3) step();
    ready     = 1'b1;
    redir     = 1'b1;
    redirAddr = 32'h80;
    step();
    chk("t4_iv_at_redirect", {31'b0, instr_valid}, 32'd1);
    redir = 1'b0;
    step();
    chk("t4_empty_after", {31'b0, instr_valid}, 32'd0);
    chk("t4_no_req_yet", {31'b0, imem_req}, 32'd0);
    step();
    chk("t4_req_issued", {31'b0, imem_req}, 32'd1);
    chk("t4_req_addr", imem_addr, 32'h80);
    for (int i = 0; i < 40 && delCnt < 1; i++) step();
    chk("t4_first_pc", at(delLog, 0), 32'h80);

    // T5: address wrap past the top of the space
    resetDut();
    ready = 1'b1;
    step();
    redir     = 1'b1;
    redirAddr = 32'hFFFF_FFFF;
    step();
    redir = 1'b0;
    for (int i = 0; i < 40 && delCnt < 3; i++) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_pc%0d", i), at(delLog, i), t5Exp[i]);
      chk($sformatf("t5_req%0d", i), at(reqLog, i + 1), t5Exp[i]);
    end

`ifdef FETCH_PERF_EN
    // T6: counters for pushes and flushed entries, cleared by reset
    resetDut();
    ready = 1'b0;
    repeat (12) step();
    chk("t6_fetched", {16'b0, perf_fetched}, 32'd4);
    chk("t6_flushed0", {16'b0, perf_flushed}, 32'd0);
    redir     = 1'b1;
    redirAddr = 32'h100;
    step();
    redir = 1'b0;
    step();
    chk("t6_flushed", {16'b0, perf_flushed}, 32'd4);
    rst = 1'b1;
    #1;
    chk("t6_rst_fetched", {16'b0, perf_fetched}, 32'd0);
    chk("t6_rst_flushed", {16'b0, perf_flushed}, 32'd0);
`endif

    // Random: stalls, variable latency, redirects incl. near wrap
    resetDut();
    randLat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0)
        redirAddr = 32'hFFFF_FFFD + 32'($urandom_range(0, 2));
      else
        redirAddr = $urandom;
      step();
    end
    redir = 1'b0;
    chk("rand_progress", {31'b0, delCnt > 100}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
